// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART-side cs/we/ack bus: default widths and arbiter state encoding.
package uart_bus_pkg;

    localparam int BUS_AW = 16;
    localparam int BUS_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    // One-hot bus owner seen from the state; 00 while idle.
    function automatic logic [1:0] grant_of(input arb_state_t st);
        case (st)
            ST_GNT0: grant_of = 2'b01;
            ST_GNT1: grant_of = 2'b10;
            default: grant_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/uart_bus_rr_pick.sv
// Combinational two-way chooser: round-robin on r_last, or M0-wins when fixed_prio is set.
module uart_bus_rr_pick
    import uart_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       r_last,
    input  logic       fixed_prio,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01: win = 2'b01;
            2'b10: win = 2'b10;
            // r_last = 1 means M1 was served last, so M0 takes the tie.
            2'b11: win = (fixed_prio || r_last) ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Two-master / one-slave arbiter for the cs/we/ack bus; grant is held until slave ack or master abort.
// Optional grant watchdog enabled by defining UART_BUS_ARB_TIMEOUT_EN.
module uart_bus_arbiter
    import uart_bus_pkg::*;
#(
    parameter int AW             = BUS_AW,
    parameter int DW             = BUS_DW,
    parameter bit FIXED_PRIO     = 1'b0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_m0_cs,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_dat,
    output logic          o_m0_ack,
    output logic [DW-1:0] o_m0_dat,
    input  logic          i_m1_cs,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_dat,
    output logic          o_m1_ack,
    output logic [DW-1:0] o_m1_dat,
    output logic          o_cs,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_dat,
    input  logic          i_ack,
    input  logic [DW-1:0] i_dat,
    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    arb_state_t state, state_nxt;
    logic       r_last;
    logic [1:0] r_owner;
    logic [1:0] req;
    logic [1:0] win;
    logic       tmo_hit;
    logic       tmo_ack0;
    logic       tmo_ack1;

    assign req = {i_m1_cs, i_m0_cs};

    uart_bus_rr_pick u_pick (
        .req        (req),
        .r_last     (r_last),
        .fixed_prio (FIXED_PRIO),
        .win        (win)
    );

`ifdef UART_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_tmo_cnt;

    // Held at zero while idle, so every grant starts counting from zero.
    always_ff @(posedge i_clk) begin
        if (i_reset || state == ST_IDLE) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end

    assign tmo_hit = (state != ST_IDLE) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        o_cs      = 1'b0;
        o_we      = 1'b0;
        o_m0_ack  = 1'b0;
        o_m1_ack  = 1'b0;
        o_timeout = 1'b0;
        tmo_ack0  = 1'b0;
        tmo_ack1  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (win[0]) begin
                    state_nxt = ST_GNT0;
                end else if (win[1]) begin
                    state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                o_cs = i_m0_cs;
                o_we = i_m0_we;
                if (!i_m0_cs) begin
                    state_nxt = ST_IDLE;
                end else if (i_ack) begin
                    o_m0_ack  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    o_m0_ack  = 1'b1;
                    tmo_ack0  = 1'b1;
                    o_timeout = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_GNT1: begin
                o_cs = i_m1_cs;
                o_we = i_m1_we;
                if (!i_m1_cs) begin
                    state_nxt = ST_IDLE;
                end else if (i_ack) begin
                    o_m1_ack  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    o_m1_ack  = 1'b1;
                    tmo_ack1  = 1'b1;
                    o_timeout = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // r_owner doubles as the address/data mux select and keeps it across idle cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            r_last  <= 1'b1;
            r_owner <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_GNT0) begin
                r_last  <= 1'b0;
                r_owner <= 2'b01;
            end else if (state == ST_IDLE && state_nxt == ST_GNT1) begin
                r_last  <= 1'b1;
                r_owner <= 2'b10;
            end
        end
    end

    always_comb begin
        o_addr = '0;
        o_dat  = '0;
        if (r_owner[1]) begin
            o_addr = i_m1_addr;
            o_dat  = i_m1_dat;
        end else if (r_owner[0]) begin
            o_addr = i_m0_addr;
            o_dat  = i_m0_dat;
        end
    end

    assign o_grant  = grant_of(state);
    assign o_m0_dat = tmo_ack0 ? {DW{1'b1}} : i_dat;
    assign o_m1_dat = tmo_ack1 ? {DW{1'b1}} : i_dat;

endmodule
